// File: rtl/seg7_scan_ctrl.sv
// Multiplexed 7-segment scan controller: one shared hex decoder, NUM_DIGITS common-anode digits,
// per-slot dead-time guard, optional leading-zero blanking.
module seg7_scan_ctrl #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int GUARD_CYC   = 500
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      enable_i,
    input  logic                      load_i,
    input  logic [4*NUM_DIGITS-1:0]   value_i,
    input  logic                      blank_lz_i,
    output logic [3:0]                hex_code_o,
    input  logic [6:0]                seg_in_i,
    output logic [6:0]                seg_out_o,
    output logic [NUM_DIGITS-1:0]     an_o,
    output logic                      frame_done_o
);

    // state   | meaning
    // S_OFF   | display dark, counters held at zero
    // S_GUARD | all anodes off, decoder pre-loaded with the upcoming digit
    // S_DRIVE | selected anode on, segments follow the decoder
    localparam logic [1:0] S_OFF   = 2'd0;
    localparam logic [1:0] S_GUARD = 2'd1;
    localparam logic [1:0] S_DRIVE = 2'd2;

    localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    localparam logic [CW-1:0] GUARD_LD = CW'(GUARD_CYC - 1);
    localparam logic [CW-1:0] DRIVE_LD = CW'(REFRESH_DIV - GUARD_CYC - 1);
    localparam logic [DW-1:0] DIG_LAST = DW'(NUM_DIGITS - 1);

    logic [1:0]              state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [DW-1:0]           digit_q, digit_d;
    logic [4*NUM_DIGITS-1:0] value_q;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic [6:0]              seg_q, seg_d;
    logic                    frame_done_q, frame_done_d;

    logic [3:0]              nib [NUM_DIGITS];
    logic [NUM_DIGITS-1:0]   blank_vec;
    logic                    zero_acc;

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_nib
        assign nib[g] = value_q[4*g +: 4];
    end

    assign hex_code_o = nib[digit_q];

    // A digit is blank when it and every more significant nibble are zero.
    always_comb begin
        zero_acc  = 1'b1;
        blank_vec = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_acc     = zero_acc & (nib[i] == 4'h0);
            blank_vec[i] = blank_lz_i && (i != 0) && zero_acc;
        end
    end

    // Prescaler is a down-counter reloaded on each phase entry; terminal count is zero.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        digit_d      = digit_q;
        frame_done_d = 1'b0;
        if (!enable_i) begin
            state_d = S_OFF;
            cnt_d   = '0;
            digit_d = '0;
        end else begin
            case (state_q)
                S_OFF: begin
                    state_d = S_GUARD;
                    cnt_d   = GUARD_LD;
                end
                S_GUARD: begin
                    if (cnt_q == '0) begin
                        state_d = S_DRIVE;
                        cnt_d   = DRIVE_LD;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                S_DRIVE: begin
                    if (cnt_q == '0) begin
                        state_d      = S_GUARD;
                        cnt_d        = GUARD_LD;
                        digit_d      = (digit_q == DIG_LAST) ? '0 : digit_q + DW'(1);
                        frame_done_d = (digit_q == DIG_LAST);
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                default: begin
                    state_d = S_OFF;
                    cnt_d   = '0;
                    digit_d = '0;
                end
            endcase
        end
    end

    // seg_in reflects the digit being driven next: GUARD already presents it to the decoder.
    always_comb begin
        an_d  = '1;
        seg_d = 7'h7F;
        if (state_d == S_DRIVE) begin
            an_d[digit_d] = 1'b0;
            if (!blank_vec[digit_d]) begin
                seg_d = seg_in_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= S_OFF;
            cnt_q        <= '0;
            digit_q      <= '0;
            value_q      <= '0;
            an_q         <= '1;
            seg_q        <= 7'h7F;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            digit_q      <= digit_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            frame_done_q <= frame_done_d;
            if (load_i) begin
                value_q <= value_i;
            end
        end
    end

    assign an_o         = an_q;
    assign seg_out_o    = seg_q;
    assign frame_done_o = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl: directed table, corner-case sequences and random stimulus,
// all checked against a slot-arithmetic reference model.
module tb_seg7_scan_ctrl;

    localparam int ND  = 4;
    localparam int RD  = 8;
    localparam int GC  = 2;
    localparam int FRM = ND * RD;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        enable_i = 1'b0;
    logic        load_i = 1'b0;
    logic [15:0] value_i = 16'h0;
    logic        blank_lz_i = 1'b0;
    logic [3:0]  hex_code_o;
    logic [6:0]  seg_in_i;
    logic [6:0]  seg_out_o;
    logic [3:0]  an_o;
    logic        frame_done_o;

    seg7_scan_ctrl #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .GUARD_CYC(GC)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .enable_i(enable_i), .load_i(load_i),
        .value_i(value_i), .blank_lz_i(blank_lz_i), .hex_code_o(hex_code_o),
        .seg_in_i(seg_in_i), .seg_out_o(seg_out_o), .an_o(an_o),
        .frame_done_o(frame_done_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [6:0] dec7(input logic [3:0] h);
        case (h)
            4'h0: dec7 = 7'h40; 4'h1: dec7 = 7'h79; 4'h2: dec7 = 7'h24; 4'h3: dec7 = 7'h30;
            4'h4: dec7 = 7'h19; 4'h5: dec7 = 7'h12; 4'h6: dec7 = 7'h02; 4'h7: dec7 = 7'h78;
            4'h8: dec7 = 7'h00; 4'h9: dec7 = 7'h10; 4'hA: dec7 = 7'h08; 4'hB: dec7 = 7'h03;
            4'hC: dec7 = 7'h46; 4'hD: dec7 = 7'h21; 4'hE: dec7 = 7'h06; default: dec7 = 7'h0E;
        endcase
    endfunction

    always_comb seg_in_i = dec7(hex_code_o);

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: run = cycles since the display was switched on (-1 = dark).
    int          run = -1;
    logic [15:0] mv = 16'h0;
    logic [3:0]  e_an, e_hex;
    logic [6:0]  e_seg;
    logic        e_fd;

    function automatic logic [3:0] nib(input logic [15:0] v, input int d);
        nib = 4'((v >> (4 * d)) & 16'hF);
    endfunction

    function automatic int m_pos();
        m_pos = (run < 0) ? -1 : run % RD;
    endfunction

    function automatic int m_dig();
        m_dig = (run < 0) ? 0 : (run / RD) % ND;
    endfunction

    task automatic model_edge();
        logic [15:0] v_old;
        int p, d;
        v_old = mv;
        if (rst_i) begin
            mv  = 16'h0;
            run = -1;
        end else begin
            if (load_i) mv = value_i;
            run = enable_i ? run + 1 : -1;
        end
        e_an  = 4'hF;
        e_seg = 7'h7F;
        e_fd  = 1'b0;
        e_hex = nib(mv, 0);
        if (run >= 0) begin
            p     = run % RD;
            d     = (run / RD) % ND;
            e_hex = nib(mv, d);
            e_fd  = (run > 0) && (run % FRM == 0);
            if (p >= GC) begin
                e_an = ~(4'b0001 << d);
                if (!(blank_lz_i && d > 0 && (v_old >> (4 * d)) == 16'h0))
                    e_seg = dec7(nib(v_old, d));
            end
        end
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        model_edge();
        #1;
        check("an", 16'(an_o), 16'(e_an));
        check("seg_out", 16'(seg_out_o), 16'(e_seg));
        check("frame_done", 16'(frame_done_o), 16'(e_fd));
        check("hex_code", 16'(hex_code_o), 16'(e_hex));
        load_i = 1'b0;
    endtask

    // Step until the model reaches the given digit and slot position, bounded.
    task automatic seek(input int dig, input int pos, input string name);
        int k;
        k = 0;
        while (!(m_dig() == dig && m_pos() == pos) && k < 2 * FRM) begin
            step();
            k++;
        end
        check({name, "_reached"}, 16'(k < 2 * FRM), 16'd1);
    endtask

    typedef struct {
        logic        en;
        logic        ld;
        logic [15:0] val;
        logic [3:0]  an;
        logic [3:0]  hex;
        logic [6:0]  seg;
        logic        fd;
    } vec_t;

    vec_t tbl[11];

    initial begin
        tbl[0]  = '{1'b1, 1'b1, 16'h1234, 4'hF, 4'h4, 7'h7F, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 16'h0000, 4'hF, 4'h4, 7'h7F, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 16'h0000, 4'hE, 4'h4, 7'h19, 1'b0};
        tbl[3]  = '{1'b1, 1'b0, 16'h0000, 4'hE, 4'h4, 7'h19, 1'b0};
        tbl[4]  = '{1'b1, 1'b0, 16'h0000, 4'hE, 4'h4, 7'h19, 1'b0};
        tbl[5]  = '{1'b1, 1'b0, 16'h0000, 4'hE, 4'h4, 7'h19, 1'b0};
        tbl[6]  = '{1'b1, 1'b0, 16'h0000, 4'hE, 4'h4, 7'h19, 1'b0};
        tbl[7]  = '{1'b1, 1'b0, 16'h0000, 4'hE, 4'h4, 7'h19, 1'b0};
        tbl[8]  = '{1'b1, 1'b0, 16'h0000, 4'hF, 4'h3, 7'h7F, 1'b0};
        tbl[9]  = '{1'b1, 1'b0, 16'h0000, 4'hF, 4'h3, 7'h7F, 1'b0};
        tbl[10] = '{1'b1, 1'b0, 16'h0000, 4'hD, 4'h3, 7'h30, 1'b0};

        // Reset held with enable high
        rst_i = 1'b1; enable_i = 1'b1;
        for (int i = 0; i < 3; i++) step();
        rst_i = 1'b0;

        // Directed scan start after loading 1234
        for (int i = 0; i < 11; i++) begin
            enable_i = tbl[i].en;
            load_i   = tbl[i].ld;
            value_i  = tbl[i].val;
            step();
            check("tbl_an", 16'(an_o), 16'(tbl[i].an));
            check("tbl_hex", 16'(hex_code_o), 16'(tbl[i].hex));
            check("tbl_seg", 16'(seg_out_o), 16'(tbl[i].seg));
            check("tbl_fd", 16'(frame_done_o), 16'(tbl[i].fd));
        end

        // frame_done period over two frames
        begin
            int pulses;
            pulses = 0;
            for (int i = 0; i < 2 * FRM; i++) begin
                step();
                if (frame_done_o) pulses++;
            end
            check("fd_count", 16'(pulses), 16'd2);
        end

        // Leading-zero blanking
        blank_lz_i = 1'b1; load_i = 1'b1; value_i = 16'h0070;
        step();
        for (int i = 0; i < FRM + 4; i++) step();
        seek(3, 4, "blank_d3");
        check("blank_d3_seg", 16'(seg_out_o), 16'h7F);
        check("blank_d3_an", 16'(an_o), 16'h7);
        seek(1, 4, "lit_d1");
        check("lit_d1_seg", 16'(seg_out_o), 16'h78);
        load_i = 1'b1; value_i = 16'h0000;
        step();
        for (int i = 0; i < FRM + 4; i++) step();
        seek(1, 4, "zero_d1");
        check("zero_d1_seg", 16'(seg_out_o), 16'h7F);
        seek(0, 4, "zero_d0");
        check("zero_d0_seg", 16'(seg_out_o), 16'h40);
        blank_lz_i = 1'b0;

        // Mid-slot load during DRIVE of digit 1
        seek(1, 4, "midload");
        load_i = 1'b1; value_i = 16'hABCD;
        step();
        check("midload_hex", 16'(hex_code_o), 16'hC);
        check("midload_an", 16'(an_o), 16'hD);

        // Load on the same edge as the digit advance
        seek(2, RD - 1, "coload");
        load_i = 1'b1; value_i = 16'h5678;
        step();
        check("coload_hex", 16'(hex_code_o), 16'h5);
        check("coload_an", 16'(an_o), 16'hF);

        // Disable mid-DRIVE of digit 2, then re-enable
        seek(2, 4, "disable");
        enable_i = 1'b0;
        step();
        check("dis_an", 16'(an_o), 16'hF);
        check("dis_fd", 16'(frame_done_o), 16'h0);
        step();
        enable_i = 1'b1;
        step();
        step();
        step();
        check("reen_an", 16'(an_o), 16'hE);
        check("reen_hex", 16'(hex_code_o), 16'h8);

        // Reset during DRIVE of digit 3
        seek(3, 5, "rstmid");
        rst_i = 1'b1;
        step();
        check("rst_an", 16'(an_o), 16'hF);
        check("rst_seg", 16'(seg_out_o), 16'h7F);
        check("rst_hex", 16'(hex_code_o), 16'h0);
        rst_i = 1'b0;

        // Random stimulus against the model
        for (int i = 0; i < 3000; i++) begin
            rst_i      = ($urandom_range(0, 299) == 0);
            enable_i   = ($urandom_range(0, 59) != 0);
            load_i     = ($urandom_range(0, 9) == 0);
            value_i    = 16'($urandom) & {{4{$urandom_range(0, 1) == 1}}, {4{$urandom_range(0, 1) == 1}},
                                          {4{$urandom_range(0, 1) == 1}}, 4'hF};
            if (i % 97 == 0) blank_lz_i = 1'($urandom_range(0, 1));
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
